// File: rtl/pwm_dac_multi_axi.sv
// Multi-channel PWM DAC: NUM_CH channels share one period counter and are
// configured through an AXI4-Lite register file with shadowed period/duty.
module pwm_dac_multi_axi #(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned PWM_WIDTH          = 12,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [NUM_CH-1:0]               pwm_out,
    output logic                            period_tick
);

    localparam int unsigned DW  = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW  = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IW  = AW - 2;
    localparam int unsigned PW  = PWM_WIDTH;
    localparam int unsigned WCW = 16;

    // Control / shadow / active state
    logic                 gen;
    logic                 sync_upd;
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    inv;
    logic [PW-1:0]        period_sh;
    logic [PW-1:0]        period_act;
    logic [PW-1:0]        duty_sh  [NUM_CH];
    logic [PW-1:0]        duty_act [NUM_CH];
    logic                 upd_pending;
    logic [WCW-1:0]       wrap_cnt;
    logic [PW-1:0]        count;

    logic                 wr_fire;
    logic                 rd_fire;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;
    logic [DW-1:0]        wmask;
    logic                 ctrl_we;
    logic                 period_we;
    logic                 status_we;
    logic [NUM_CH-1:0]    duty_we;
    logic                 gen_rise;
    logic                 wrap;
    logic                 load_all;
    logic [DW-1:0]        rd_word;
    logic                 unused_ok;

    // Handshakes complete in the cycle the request is presented and the slot is free
    assign wr_fire       = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
    assign rd_fire       = s_axi_arvalid & ~s_axi_rvalid;
    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign s_axi_arready = rd_fire;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;

    assign wr_idx = s_axi_awaddr[AW-1:2];
    assign rd_idx = s_axi_araddr[AW-1:2];

    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, wmask, s_axi_wstrb};

    // Write decode and per-byte strobe mask
    always_comb begin
        wmask     = '0;
        ctrl_we   = wr_fire && (wr_idx == IW'(0));
        period_we = wr_fire && (wr_idx == IW'(1));
        status_we = wr_fire && (wr_idx == IW'(2));
        duty_we   = '0;
        for (int b = 0; b < int'(DW / 8); b++) begin
            wmask[8*b +: 8] = {8{s_axi_wstrb[b]}};
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            duty_we[c] = wr_fire && (wr_idx == IW'(4 + c));
        end
    end

    assign gen_rise = ctrl_we & s_axi_wstrb[0] & s_axi_wdata[0] & ~gen;
    assign wrap     = gen & (count >= period_act);
    // Non-sync mode tracks the shadows one cycle behind; sync mode only on wrap
    assign load_all = ~sync_upd | gen_rise | wrap;

    // Read mux: shadow values, unmapped words read as zero
    always_comb begin
        rd_word = '0;
        if (rd_idx == IW'(0)) begin
            rd_word[0]           = gen;
            rd_word[1]           = sync_upd;
            rd_word[8 +: NUM_CH]  = ch_en;
            rd_word[16 +: NUM_CH] = inv;
        end else if (rd_idx == IW'(1)) begin
            rd_word[PW-1:0] = period_sh;
        end else if (rd_idx == IW'(2)) begin
            rd_word[0]          = upd_pending;
            rd_word[DW-1 -: WCW] = wrap_cnt;
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (rd_idx == IW'(4 + c)) begin
                rd_word[PW-1:0] = duty_sh[c];
            end
        end
    end

    // AXI response channels
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            if (wr_fire) begin
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (rd_fire) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Register file, shadows and active copies
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gen         <= 1'b0;
            sync_upd    <= 1'b0;
            ch_en       <= '0;
            inv         <= '0;
            period_sh   <= '0;
            period_act  <= '0;
            upd_pending <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                duty_sh[c]  <= '0;
                duty_act[c] <= '0;
            end
        end else begin
            if (ctrl_we) begin
                if (s_axi_wstrb[0]) begin
                    gen      <= s_axi_wdata[0];
                    sync_upd <= s_axi_wdata[1];
                end
                if (s_axi_wstrb[1]) ch_en <= s_axi_wdata[8 +: NUM_CH];
                if (s_axi_wstrb[2]) inv   <= s_axi_wdata[16 +: NUM_CH];
            end
            if (period_we) begin
                period_sh <= (period_sh & ~wmask[PW-1:0]) | (s_axi_wdata[PW-1:0] & wmask[PW-1:0]);
            end
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (duty_we[c]) begin
                    duty_sh[c] <= (duty_sh[c] & ~wmask[PW-1:0]) | (s_axi_wdata[PW-1:0] & wmask[PW-1:0]);
                end
            end
            if (load_all) begin
                period_act <= period_sh;
                for (int c = 0; c < int'(NUM_CH); c++) begin
                    duty_act[c] <= duty_sh[c];
                end
            end
            // A shadow write landing on the wrap cycle stays pending for the next wrap
            if (gen_rise) begin
                upd_pending <= 1'b0;
            end else if (sync_upd && (period_we || (|duty_we))) begin
                upd_pending <= 1'b1;
            end else if (wrap) begin
                upd_pending <= 1'b0;
            end
        end
    end

    // Period counter, wrap counter and outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count       <= '0;
            wrap_cnt    <= '0;
            period_tick <= 1'b0;
            pwm_out     <= '0;
        end else begin
            if (!gen || wrap) begin
                count <= '0;
            end else begin
                count <= count + PW'(1);
            end
            if (status_we) begin
                wrap_cnt <= '0;
            end else if (wrap) begin
                wrap_cnt <= wrap_cnt + WCW'(1);
            end
            period_tick <= wrap;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                pwm_out[c] <= (gen && ch_en[c]) ? ((count < duty_act[c]) ^ inv[c]) : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_dac_multi_axi.sv
// Self-checking bench for pwm_dac_multi_axi: directed AXI/PWM scenarios plus
// randomized configurations checked against an arithmetic waveform model.
module tb_pwm_dac_multi_axi;

    localparam int NCH = 4;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [5:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [NCH-1:0] pwm_out;
    logic        period_tick;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    int unsigned cyc    = 0;
    logic [31:0] pat [NCH];
    logic [31:0] tpat;

    pwm_dac_multi_axi #(.NUM_CH(NCH), .PWM_WIDTH(12), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected PWM pattern over one period: bit k = sample k after the wrap
    function automatic logic [31:0] exp_wave(input int d, input int p, input bit en, input bit iv);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k <= p; k++) w[k] = en & ((k < d) ^ iv);
        return w;
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge ACLK);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1; n = 0;
        while (!(awready && wready) && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        chk("aw_handshake", 32'(awready & wready), 32'd1);
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_rise", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge ACLK);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n;
        @(negedge ACLK);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        #1; n = 0;
        while (!arready && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        chk("ar_handshake", 32'(arready), 32'd1);
        @(negedge ACLK);
        arvalid = 1'b0;
        chk("rvalid_rise", 32'(rvalid), 32'd1);
        chk("rresp", 32'(rresp), 32'd0);
        d = rdata;
        rready = 1'b1;
        @(negedge ACLK);
        rready = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge ACLK); n++;
        end while (!period_tick && n < 200);
        chk("tick_seen", 32'(period_tick), 32'd1);
    endtask

    task automatic measure(input int plen);
        wait_tick();
        for (int c = 0; c < NCH; c++) pat[c] = '0;
        tpat = '0;
        for (int k = 0; k < plen; k++) begin
            @(negedge ACLK);
            for (int c = 0; c < NCH; c++) pat[c][k] = pwm_out[c];
            tpat[k] = period_tick;
        end
    endtask

    task automatic check_regs_zero(input string tag);
        logic [5:0]  addrs [7];
        logic [31:0] d;
        addrs = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18, 6'h1C};
        for (int i = 0; i < 7; i++) begin
            axi_read(addrs[i], d);
            chk(tag, d, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] r0;
        int          t0;
        int          k;
        int          n;
        bit          ok;
        bit          no_acc;
        int          duty_init [NCH];

        // Reset state
        repeat (3) @(negedge ACLK);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rst_tick", 32'(period_tick), 32'd0);
        check_regs_zero("rst_reg");

        // Directed configuration: PERIOD=9, duties 0,3,10,5, CTRL=0x0F03
        duty_init = '{0, 3, 10, 5};
        axi_write(6'h04, 32'd9, 4'hF);
        for (int c = 0; c < NCH; c++) axi_write(6'(16 + 4 * c), 32'(duty_init[c]), 4'hF);
        axi_write(6'h00, 32'h0000_0F03, 4'hF);
        axi_read(6'h04, d); chk("rd_period", d, 32'd9);
        axi_read(6'h14, d); chk("rd_duty1", d, 32'd3);
        axi_read(6'h18, d); chk("rd_duty2", d, 32'd10);
        axi_read(6'h00, d); chk("rd_ctrl", d, 32'h0000_0F03);
        axi_read(6'h08, d); chk("pending_after_gen", d & 32'h1, 32'd0);
        measure(10);
        for (int c = 0; c < NCH; c++) chk($sformatf("dir_wave_ch%0d", c), pat[c], exp_wave(duty_init[c], 9, 1'b1, 1'b0));
        chk("dir_tick_pattern", tpat, 32'h200);

        // SYNC_UPD: duty write mid-period stays pending until the wrap
        t0 = int'(cyc);
        axi_write(6'h14, 32'd7, 4'hF);
        axi_read(6'h08, d); chk("sync_pending_set", d & 32'h1, 32'd1);
        ok = 1'b1; n = 0;
        do begin
            @(negedge ACLK); n++;
            k = int'(cyc) - t0 - 1;
            if (pwm_out[1] !== 1'(k < 3)) ok = 1'b0;
        end while (!period_tick && n < 40);
        chk("sync_old_duty_held", 32'(ok), 32'd1);
        chk("sync_wrap_reached", 32'(period_tick), 32'd1);
        measure(10);
        chk("sync_new_duty", pat[1], exp_wave(7, 9, 1'b1, 1'b0));
        axi_read(6'h08, d); chk("sync_pending_clr", d & 32'h1, 32'd0);

        // INV and enable: ch1 inverted, ch3 disabled but inverted
        axi_write(6'h14, 32'd3, 4'hF);
        axi_write(6'h00, 32'h000A_0701, 4'hF);
        measure(10);
        chk("inv_ch0", pat[0], exp_wave(0, 9, 1'b1, 1'b0));
        chk("inv_ch1", pat[1], exp_wave(3, 9, 1'b1, 1'b1));
        chk("inv_ch2", pat[2], exp_wave(10, 9, 1'b1, 1'b0));
        chk("inv_ch3_disabled", pat[3], 32'd0);

        // Write back-pressure: bvalid holds, second write waits
        @(negedge ACLK);
        awaddr = 6'h18; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        #1; chk("bp_first_aw", 32'(awready), 32'd1);
        @(negedge ACLK);
        wdata = 32'h22;
        ok = 1'b1; no_acc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1) ok = 1'b0;
            if (awready !== 1'b0 || wready !== 1'b0) no_acc = 1'b0;
            @(negedge ACLK);
        end
        chk("bp_bvalid_hold", 32'(ok), 32'd1);
        chk("bp_no_second_aw", 32'(no_acc), 32'd1);
        bready = 1'b1;
        @(negedge ACLK);
        chk("bp_second_aw", 32'(awready), 32'd1);
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_bvalid", 32'(bvalid), 32'd1);
        @(negedge ACLK);
        bready = 1'b0;
        axi_read(6'h18, d); chk("bp_second_data", d, 32'h22);

        // Read back-pressure: rvalid/rdata stable, second read waits
        @(negedge ACLK);
        araddr = 6'h04; arvalid = 1'b1; rready = 1'b0;
        #1; chk("bp_first_ar", 32'(arready), 32'd1);
        @(negedge ACLK);
        araddr = 6'h18;
        r0 = rdata;
        chk("bp_first_rdata", r0, 32'd9);
        ok = 1'b1; no_acc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rvalid !== 1'b1 || rdata !== 32'd9) ok = 1'b0;
            if (arready !== 1'b0) no_acc = 1'b0;
            @(negedge ACLK);
        end
        chk("bp_rdata_hold", 32'(ok), 32'd1);
        chk("bp_no_second_ar", 32'(no_acc), 32'd1);
        rready = 1'b1;
        @(negedge ACLK);
        chk("bp_second_ar", 32'(arready), 32'd1);
        @(negedge ACLK);
        arvalid = 1'b0;
        chk("bp_second_rdata", rdata, 32'h22);
        @(negedge ACLK);
        rready = 1'b0;

        // Byte strobes and unmapped addresses
        axi_write(6'h04, 32'h0000_ABCD, 4'h1);
        axi_read(6'h04, d); chk("strb_low_byte", d, 32'h0CD);
        axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF);
        axi_read(6'h3C, d); chk("unmapped_3c", d, 32'd0);
        axi_read(6'h20, d); chk("unmapped_ch4", d, 32'd0);

        // Wrap counter: clear, count three wraps, then stop
        axi_write(6'h00, 32'd0, 4'hF);
        axi_write(6'h04, 32'd9, 4'hF);
        axi_write(6'h08, 32'd0, 4'hF);
        axi_read(6'h08, d); chk("wrapcnt_clear", d, 32'd0);
        axi_write(6'h00, 32'h0000_0F01, 4'hF);
        repeat (3) wait_tick();
        axi_write(6'h00, 32'd0, 4'hF);
        axi_read(6'h08, d); chk("wrapcnt_three", d, 32'h0003_0000);

        // Randomized configurations against the waveform model
        for (int it = 0; it < 6; it++) begin
            int          p;
            int          dd [NCH];
            logic [3:0]  en;
            logic [3:0]  iv;
            logic        sy;
            logic [31:0] ctrl;
            int          rc;
            p  = int'($urandom_range(20, 1));
            for (int c = 0; c < NCH; c++) dd[c] = int'($urandom_range(p + 2, 0));
            en = 4'($urandom);
            iv = 4'($urandom);
            sy = 1'($urandom);
            ctrl = {12'd0, iv, 4'd0, en, 6'd0, sy, 1'b1};
            axi_write(6'h00, 32'd0, 4'hF);
            axi_write(6'h04, 32'(p), 4'hF);
            for (int c = 0; c < NCH; c++) axi_write(6'(16 + 4 * c), 32'(dd[c]), 4'hF);
            chk("rnd_gen_off", 32'(pwm_out), 32'd0);
            rc = int'($urandom_range(NCH - 1, 0));
            axi_read(6'(16 + 4 * rc), d); chk("rnd_duty_rd", d, 32'(dd[rc]));
            axi_write(6'h00, ctrl, 4'hF);
            axi_read(6'h00, d); chk("rnd_ctrl_rd", d, ctrl);
            measure(p + 1);
            for (int c = 0; c < NCH; c++) chk($sformatf("rnd%0d_ch%0d", it, c), pat[c], exp_wave(dd[c], p, en[c], iv[c]));
            chk($sformatf("rnd%0d_tick", it), tpat, 32'd1 << p);
        end

        // Reset mid-write with a channel held high
        axi_write(6'h00, 32'd0, 4'hF);
        axi_write(6'h04, 32'd9, 4'hF);
        axi_write(6'h18, 32'hFFF, 4'hF);
        axi_write(6'h00, 32'h0000_0401, 4'hF);
        repeat (3) @(negedge ACLK);
        chk("pre_rst_ch2_high", 32'(pwm_out), 32'h4);
        @(negedge ACLK);
        awaddr = 6'h10; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("midrst_bvalid", 32'(bvalid), 32'd0);
        chk("midrst_pwm", 32'(pwm_out), 32'd0);
        chk("midrst_tick", 32'(period_tick), 32'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        check_regs_zero("midrst_reg");
        chk("post_rst_pwm", 32'(pwm_out), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
